// File: rtl/carry_resolver.sv
// Carry resolution stage of the arithmetic encoder: holds one pending byte plus a
// counted run of 0xFF bytes and releases them once a later carry (or its absence) is known.
module carry_resolver #(
  parameter int unsigned RUN_CNT_WIDTH  = 16,
  parameter int unsigned BYTE_CNT_WIDTH = 32
) (
  input  logic                      general_clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [8:0]                in_byte,
  output logic                      in_ready,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [7:0]                out_byte,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      done,
  output logic [BYTE_CNT_WIDTH-1:0] byte_count,
  output logic                      err_carry
);

  typedef enum logic [2:0] {
    IDLE, HOLD, EMIT_PEND, EMIT_RUN, FLUSH_PEND, FLUSH_RUN, DONE
  } state_t;

  localparam logic [RUN_CNT_WIDTH-1:0]  RUN_ONE  = RUN_CNT_WIDTH'(1);
  localparam logic [BYTE_CNT_WIDTH-1:0] BYTE_ONE = BYTE_CNT_WIDTH'(1);

  state_t                    state, state_n;
  logic [7:0]                pending, pending_n;
  logic [7:0]                nxt, nxt_n;
  logic [RUN_CNT_WIDTH-1:0]  run, run_n;
  logic                      c, c_n;
  logic                      flush_req, flush_req_n;
  logic                      err_n;
  logic [BYTE_CNT_WIDTH-1:0] count_n;
  logic                      accept, handshake;
  logic                      in_ready_n, out_valid_n, out_last_n, done_n;
  logic [7:0]                out_byte_n;

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  always_comb begin
    state_n     = state;
    pending_n   = pending;
    nxt_n       = nxt;
    run_n       = run;
    c_n         = c;
    flush_req_n = flush_req | flush;
    err_n       = err_carry;
    count_n     = handshake ? byte_count + BYTE_ONE : byte_count;

    unique case (state)
      IDLE: begin
        if (accept) begin
          pending_n = in_byte[7:0];
          run_n     = '0;
          state_n   = HOLD;
          if (in_byte[8]) err_n = 1'b1;
        end else if (flush_req) begin
          state_n = DONE;
        end
      end
      HOLD: begin
        if (accept) begin
          if (!in_byte[8] && in_byte[7:0] == 8'hFF) begin
            run_n = run + RUN_ONE;
          end else begin
            c_n     = in_byte[8];
            nxt_n   = in_byte[7:0];
            state_n = EMIT_PEND;
          end
        end else if (flush_req) begin
          state_n = FLUSH_PEND;
        end
      end
      EMIT_PEND: begin
        if (handshake) begin
          if (run != '0) begin
            state_n = EMIT_RUN;
          end else begin
            pending_n = nxt;
            state_n   = HOLD;
          end
        end
      end
      EMIT_RUN: begin
        if (handshake) begin
          run_n = run - RUN_ONE;
          if (run == RUN_ONE) begin
            pending_n = nxt;
            state_n   = HOLD;
          end
        end
      end
      FLUSH_PEND: begin
        if (handshake) state_n = (run != '0) ? FLUSH_RUN : DONE;
      end
      FLUSH_RUN: begin
        if (handshake) begin
          run_n = run - RUN_ONE;
          if (run == RUN_ONE) state_n = DONE;
        end
      end
      DONE: begin
        flush_req_n = 1'b0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // A carry into a pending 0xFF overflows out of the held window and is lost.
    if (state_n == EMIT_PEND && state != EMIT_PEND && pending_n == 8'hFF && c_n)
      err_n = 1'b1;
  end

  // Outputs are decoded from the next state so they come straight out of flops.
  always_comb begin
    out_valid_n = 1'b0;
    out_byte_n  = '0;
    out_last_n  = 1'b0;
    unique case (state_n)
      EMIT_PEND: begin
        out_valid_n = 1'b1;
        out_byte_n  = pending_n + {7'b0, c_n};
      end
      EMIT_RUN: begin
        out_valid_n = 1'b1;
        out_byte_n  = c_n ? 8'h00 : 8'hFF;
      end
      FLUSH_PEND: begin
        out_valid_n = 1'b1;
        out_byte_n  = pending_n;
        out_last_n  = (run_n == '0);
      end
      FLUSH_RUN: begin
        out_valid_n = 1'b1;
        out_byte_n  = 8'hFF;
        out_last_n  = (run_n == RUN_ONE);
      end
      default: ;
    endcase
    done_n     = (state_n == DONE);
    in_ready_n = (state_n == IDLE) ||
                 (state_n == HOLD && run_n != '1 && !flush_req_n);
  end

  always_ff @(posedge general_clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      nxt        <= '0;
      run        <= '0;
      c          <= 1'b0;
      flush_req  <= 1'b0;
      err_carry  <= 1'b0;
      byte_count <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_byte   <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      nxt        <= nxt_n;
      run        <= run_n;
      c          <= c_n;
      flush_req  <= flush_req_n;
      err_carry  <= err_n;
      byte_count <= count_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      out_byte   <= out_byte_n;
      out_last   <= out_last_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_carry_resolver.sv
// Bench for carry_resolver: directed frame table, hand-written timing sequences and
// random frames checked against a ripple-carry byte-queue reference model.
`timescale 1ns/1ps
module tb_carry_resolver;
  localparam int unsigned RCW = 4;
  localparam int unsigned BCW = 6;

  logic           general_clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic [8:0]     in_byte = '0;
  logic           flush = 1'b0;
  logic           out_ready = 1'b0;
  logic           in_ready, out_valid, out_last, done, err_carry;
  logic [7:0]     out_byte;
  logic [BCW-1:0] byte_count;

  int tests = 0;
  int fails = 0;

  always #5 general_clk = ~general_clk;

  carry_resolver #(.RUN_CNT_WIDTH(RCW), .BYTE_CNT_WIDTH(BCW)) dut (
    .general_clk(general_clk), .reset(reset),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last), .out_ready(out_ready),
    .done(done), .byte_count(byte_count), .err_carry(err_carry)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: held bytes await a possible carry; a carry ripples up through them.
  typedef struct packed { logic [7:0] b; logic last; } ob_t;
  logic [7:0]     held[$];
  ob_t            expq[$];
  ob_t            cap[$];
  bit             m_err;
  logic [BCW-1:0] emitted;
  bit             rnd_ready = 1'b0;

  function automatic void model_reset();
    held.delete(); expq.delete(); cap.delete();
    m_err = 1'b0; emitted = '0;
  endfunction

  function automatic void model_accept(input logic [8:0] v);
    int i;
    bit cy;
    if (held.size() == 0) begin
      if (v[8]) m_err = 1'b1;
      held.push_back(v[7:0]);
    end else if (!v[8] && v[7:0] == 8'hFF) begin
      held.push_back(8'hFF);
    end else begin
      if (v[8]) begin
        i = held.size() - 1;
        cy = 1'b1;
        while (cy && i >= 0) begin
          held[i] = held[i] + 8'd1;
          cy = (held[i] == 8'h00);
          i--;
        end
        if (cy) m_err = 1'b1;
      end
      foreach (held[k]) expq.push_back('{b: held[k], last: 1'b0});
      held.delete();
      held.push_back(v[7:0]);
    end
  endfunction

  function automatic void model_flush();
    foreach (held[k]) expq.push_back('{b: held[k], last: (k == held.size() - 1)});
    held.delete();
  endfunction

  // Output monitor, sampled 1ns after the falling edge.
  bit         prev_stall = 1'b0, prev_done = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_byte = '0;
  always begin
    ob_t e;
    @(negedge general_clk);
    #1;
    if (reset) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_byte", out_byte, prev_byte);
        check("stall_last", out_last, prev_last);
      end
      if (done) check("done_one_cycle", prev_done, 1'b0);
      prev_done = done;
      if (out_valid && out_ready) begin
        check("byte_count_live", byte_count, emitted);
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %0h expected no byte", out_byte);
        end else begin
          e = expq.pop_front();
          check("out_byte", out_byte, e.b);
          check("out_last", out_last, e.last);
        end
        cap.push_back('{b: out_byte, last: out_last});
        emitted++;
      end
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_byte;
      prev_last  = out_last;
    end
  end

  always @(negedge general_clk) if (rnd_ready) out_ready = ($urandom_range(0, 9) < 7);

  // Main-thread tasks always start and end on a falling edge.
  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    model_reset();
    @(negedge general_clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [8:0] v, input bit fl);
    int unsigned t = 0;
    in_byte = v;
    in_valid = 1'b1;
    while (!in_ready && t < 2000) begin
      @(negedge general_clk);
      t++;
    end
    if (!in_ready) begin
      check("send_ready_timeout", in_ready, 1'b1);
    end else begin
      flush = fl;
      model_accept(v);
      if (fl) model_flush();
      @(negedge general_clk);
    end
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    model_flush();
    @(negedge general_clk);
    flush = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned t = 0;
    while (!done && t < 3000) begin
      @(negedge general_clk);
      t++;
    end
    check("done_seen", done, 1'b1);
    @(negedge general_clk);
    check("model_drained", expq.size(), 0);
  endtask

  task automatic check_reset_state();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_byte", out_byte, 8'h00);
    check("rst_out_last", out_last, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_byte_count", byte_count, '0);
    check("rst_err_carry", err_carry, 1'b0);
  endtask

  typedef struct packed {
    logic [0:4][8:0] in_b;
    logic [2:0]      n_in;
    logic            fl_last;
    logic [0:4][7:0] exp_b;
    logic [2:0]      n_out;
    logic            exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] exp5[5];
    int unsigned n;
    logic [8:0] v;
    int unsigned r;

    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp5[5];
    int unsigned n;
    logic [8:0] v;
    int unsigned r;

    tbl[0] = '{in_b: {9'h012, 9'h034, 9'h056, 9'h000, 9'h000}, n_in: 3'd3, fl_last: 1'b1,
               exp_b: {8'h12, 8'h34, 8'h56, 8'h00, 8'h00}, n_out: 3'd3, exp_err: 1'b0};
    tbl[1] = '{in_b: {9'h012, 9'h0FF, 9'h0FF, 9'h105, 9'h000}, n_in: 3'd4, fl_last: 1'b0,
               exp_b: {8'h13, 8'h00, 8'h00, 8'h05, 8'h00}, n_out: 3'd4, exp_err: 1'b0};
    tbl[2] = '{in_b: {9'h012, 9'h0FF, 9'h0FF, 9'h005, 9'h000}, n_in: 3'd4, fl_last: 1'b0,
               exp_b: {8'h12, 8'hFF, 8'hFF, 8'h05, 8'h00}, n_out: 3'd4, exp_err: 1'b0};
    tbl[3] = '{in_b: {9'h1AA, 9'h000, 9'h000, 9'h000, 9'h000}, n_in: 3'd1, fl_last: 1'b0,
               exp_b: {8'hAA, 8'h00, 8'h00, 8'h00, 8'h00}, n_out: 3'd1, exp_err: 1'b1};
    tbl[4] = '{in_b: {9'h0FF, 9'h101, 9'h000, 9'h000, 9'h000}, n_in: 3'd2, fl_last: 1'b1,
               exp_b: {8'h00, 8'h01, 8'h00, 8'h00, 8'h00}, n_out: 3'd2, exp_err: 1'b1};
    tbl[5] = '{in_b: {9'h000, 9'h000, 9'h000, 9'h000, 9'h000}, n_in: 3'd0, fl_last: 1'b0,
               exp_b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n_out: 3'd0, exp_err: 1'b0};
    tbl[6] = '{in_b: {9'h012, 9'h0FF, 9'h0FF, 9'h0FF, 9'h000}, n_in: 3'd4, fl_last: 1'b1,
               exp_b: {8'h12, 8'hFF, 8'hFF, 8'hFF, 8'h00}, n_out: 3'd4, exp_err: 1'b0};
    tbl[7] = '{in_b: {9'h080, 9'h1FF, 9'h000, 9'h000, 9'h000}, n_in: 3'd2, fl_last: 1'b0,
               exp_b: {8'h81, 8'hFF, 8'h00, 8'h00, 8'h00}, n_out: 3'd2, exp_err: 1'b0};

    model_reset();
    repeat (2) @(negedge general_clk);
    check_reset_state();
    reset = 1'b0;
    @(negedge general_clk);

    // Directed frames.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      for (int k = 0; k < int'(tbl[i].n_in); k++)
        send(tbl[i].in_b[k], tbl[i].fl_last && (k == int'(tbl[i].n_in) - 1));
      if (!(tbl[i].fl_last && tbl[i].n_in != 0)) pulse_flush();
      wait_done();
      check($sformatf("tbl%0d_count", i), cap.size(), tbl[i].n_out);
      for (int k = 0; k < int'(tbl[i].n_out) && k < cap.size(); k++) begin
        check($sformatf("tbl%0d_byte%0d", i, k), cap[k].b, tbl[i].exp_b[k]);
        check($sformatf("tbl%0d_last%0d", i, k), cap[k].last, (k == int'(tbl[i].n_out) - 1));
      end
      check($sformatf("tbl%0d_byte_count", i), byte_count, tbl[i].n_out);
      check($sformatf("tbl%0d_err", i), err_carry, tbl[i].exp_err);
    end

    // First resolved byte one cycle after the closing accept; n+1 cycle drain.
    do_reset();
    out_ready = 1'b1;
    send(9'h012, 1'b0);
    send(9'h034, 1'b0);
    check("lat_out_valid", out_valid, 1'b1);
    check("lat_out_byte", out_byte, 8'h12);
    check("lat_in_ready_low", in_ready, 1'b0);
    @(negedge general_clk);
    check("lat_in_ready_back", in_ready, 1'b1);
    send(9'h0FF, 1'b0);
    send(9'h0FF, 1'b0);
    send(9'h005, 1'b0);
    n = 0;
    while (out_valid && n < 10) begin
      n++;
      @(negedge general_clk);
    end
    check("drain_cycles_run2", n, 3);
    pulse_flush();
    wait_done();

    // out_ready toggling during a run of three.
    do_reset();
    out_ready = 1'b0;
    send(9'h012, 1'b0);
    repeat (3) send(9'h0FF, 1'b0);
    send(9'h105, 1'b0);
    for (int k = 0; k < 12; k++) begin
      out_ready = (k % 2 == 0);
      @(negedge general_clk);
    end
    out_ready = 1'b1;
    pulse_flush();
    wait_done();
    exp5 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h05};
    check("toggle_count", cap.size(), 5);
    for (int k = 0; k < 5 && k < cap.size(); k++)
      check($sformatf("toggle_byte%0d", k), cap[k].b, exp5[k]);

    // Reset while emitting the run.
    do_reset();
    out_ready = 1'b0;
    send(9'h012, 1'b0);
    repeat (3) send(9'h0FF, 1'b0);
    send(9'h034, 1'b0);
    out_ready = 1'b1;
    @(negedge general_clk);
    out_ready = 1'b0;
    check("run_state_valid", out_valid, 1'b1);
    check("run_state_byte", out_byte, 8'hFF);
    do_reset();
    check_reset_state();
    out_ready = 1'b1;
    send(9'h056, 1'b0);
    send(9'h078, 1'b0);
    pulse_flush();
    wait_done();
    check("post_reset_count", cap.size(), 2);

    // Run counter saturation stalls upstream until flush.
    do_reset();
    out_ready = 1'b1;
    send(9'h012, 1'b0);
    for (int k = 0; k < (1 << RCW) - 1; k++) send(9'h0FF, 1'b0);
    check("sat_in_ready", in_ready, 1'b0);
    repeat (3) @(negedge general_clk);
    check("sat_in_ready_hold", in_ready, 1'b0);
    check("sat_no_output", out_valid, 1'b0);
    pulse_flush();
    wait_done();
    check("sat_count", cap.size(), 1 << RCW);
    check("sat_byte_count", byte_count, 1 << RCW);

    // Random frames against the model.
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      if (f % 10 == 0) do_reset();
      n = $urandom_range(1, 14);
      for (int k = 0; k < int'(n); k++) begin
        r = $urandom_range(0, 99);
        if (r < 45)      v = 9'h0FF;
        else if (r < 60) v = {1'b1, 8'($urandom)};
        else             v = {1'b0, 8'($urandom)};
        if (v == 9'h0FF && held.size() == (1 << RCW)) v = 9'h0FE;
        send(v, (k == int'(n) - 1) && ($urandom_range(0, 1) == 1));
      end
      if (held.size() != 0 || $urandom_range(0, 3) == 0) pulse_flush();
      else pulse_flush();
      wait_done();
      check($sformatf("rnd%0d_err", f), err_carry, m_err);
      check($sformatf("rnd%0d_byte_count", f), byte_count, emitted);
    end
    rnd_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/carry_resolver.md
# carry_resolver

Final output stage of the arithmetic encoder: consumes the 9-bit pre-carry bytes produced by renormalization (bit 8 = carry into the previous byte, bits 7:0 = byte value) and resolves carry propagation through runs of 0xFF. Emits final bitstream bytes over a valid/ready interface, plus a last-byte marker on frame flush. Holds one pending byte and a counted run of 0xFF bytes, so storage does not grow with run length.

## Interface
- RUN_CNT_WIDTH, 16, width of the pending-0xFF run counter
- BYTE_CNT_WIDTH, 32, width of the emitted-byte counter
- general_clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock, sampled at the rising edge
- in_valid  in  1  pre-carry byte present
- in_byte  in  9  {carry, byte[7:0]}
- in_ready  out  1  block accepts in_byte this cycle
- flush  in  1  one-cycle pulse: end of frame, drain everything
- out_valid  out  1  out_byte valid
- out_byte  out  8  resolved bitstream byte
- out_last  out  1  qualifies the final byte of a flushed frame
- out_ready  in  1  downstream accepts out_byte
- done  out  1  one-cycle pulse after the frame is fully drained
- byte_count  out  BYTE_CNT_WIDTH  bytes emitted since reset
- err_carry  out  1  sticky: carry arrived with no pending byte, or pending 0xFF received a carry

## Operation
- Registers: pending[7:0], run[RUN_CNT_WIDTH-1:0], nxt[7:0], c (latched carry), flush_req, state.
- States: IDLE, HOLD, EMIT_PEND, EMIT_RUN, FLUSH_PEND, FLUSH_RUN, DONE.
- Accept = in_valid & in_ready. in_ready = 1 in IDLE; in HOLD when run != all-ones and flush_req = 0; 0 elsewhere.
- IDLE, accept: pending = byte, run = 0, go HOLD. If carry = 1, set err_carry and drop the carry.
- IDLE, flush_req with nothing pending: go DONE; no bytes emitted.
- HOLD, accept with carry = 0 and byte = 0xFF: run++ and stay in HOLD.
- HOLD, any other accept: c = carry, nxt = byte, go EMIT_PEND.
- EMIT_PEND: out_byte = pending + c (mod 256). If pending = 0xFF and c = 1, set err_carry. On out_ready: if run > 0 go EMIT_RUN, else pending = nxt and go HOLD.
- EMIT_RUN: out_byte = c ? 0x00 : 0xFF. On out_ready: run--. When the handshake sees run = 1: pending = nxt, run = 0, go HOLD.
- flush: pulse latched into flush_req. If the same cycle has an accept, the byte is processed first. flush_req is acted on only in HOLD or IDLE.
- HOLD with flush_req: go FLUSH_PEND.
- FLUSH_PEND: out_byte = pending; out_last = (run = 0).
- FLUSH_RUN: emits 0xFF run times. out_last is set on the last one.
- After the last handshake: go DONE. DONE asserts done for one cycle, clears flush_req, returns to IDLE.
- byte_count increments on every out handshake and wraps modulo 2^BYTE_CNT_WIDTH.
- Run saturation: in_ready stays low while run is all-ones, so upstream stalls until a flush.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_byte 0, out_last 0, done 0, byte_count 0, err_carry 0, run 0, flush_req 0.
- Outputs are registered from state; out_valid and out_byte stay stable until out_ready.
- Latency: the first resolved byte appears 1 cycle after the accept that closes a run (HOLD -> EMIT_PEND).
- A run of n 0xFF bytes drains in n+1 cycles with out_ready held high.
- A non-FF byte accepted into HOLD costs one cycle of in_ready low per emitted byte.
- Reset mid-frame discards pending, run and flush_req with no output.

## Test plan
- Bytes 0x12, 0x34, 0x56, then flush, out_ready = 1 -> out 0x12, 0x34, 0x56 (last); done 1 cycle after; byte_count = 3.
- 0x12, 0xFF, 0xFF, then 0x105 (carry) -> 0x13, 0x00, 0x00; pending = 0x05.
- 0x12, 0xFF, 0xFF, then 0x005 -> 0x12, 0xFF, 0xFF; flush then emits 0x05 with out_last.
- out_ready toggling 1010 during a run of 3 -> no byte lost or duplicated; out_byte stable while stalled.
- First byte 0x1AA -> err_carry = 1, pending = 0xAA. Pending 0xFF (first byte) followed by 0x101 -> err_carry = 1, out 0x00.
- flush and in_valid asserted in the same cycle -> byte included before drain. Reset during EMIT_RUN -> out_valid 0 the next cycle and all counters 0.
